clk_sel_ctrl: RTL and testbench

Control-side stage directly upstream of the glitch-free three-source clock mux. Accepts clock-source switch requests over a valid/ready handshake, drives the mux select `sel_clk`, and holds off further requests for a settle window so the mux's two-stage enable synchroniser and negedge hand-off can complete. Also forces a fallback to source 0 when the selected source is flagged dead. Runs on an always-on reference clock, not on any muxed clock.

---
 rtl/clk_sel_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_sel_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// Select controller for the glitch-free three-source clock mux: handshaked
// switch requests, a settle hold-off after every change, and forced fallback to source 0.
module clk_sel_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    input  logic [2:0]       clk_fail,
    output logic [1:0]       sel_clk,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             fallback,
    output logic [CNT_W-1:0] switch_cnt
);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       sel_q, sel_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fb_q, fb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic curFail;
    logic reqFail;
    logic needFb;
    logic accept;
    logic cntSat;

    // Code 3 never names a live source, so it reads as dead.
    always_comb begin
        curFail = 1'b1;
        reqFail = 1'b1;
        case (sel_q)
            2'd0:    curFail = clk_fail[0];
            2'd1:    curFail = clk_fail[1];
            2'd2:    curFail = clk_fail[2];
            default: curFail = 1'b1;
        endcase
        case (req_sel)
            2'd0:    reqFail = clk_fail[0];
            2'd1:    reqFail = clk_fail[1];
            2'd2:    reqFail = clk_fail[2];
            default: reqFail = 1'b1;
        endcase
    end

    assign needFb    = curFail && (sel_q != 2'd0);
    assign req_ready = (state_q == IDLE) && !needFb;
    assign accept    = req_valid && req_ready;
    assign cntSat    = &cnt_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fb_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (needFb) begin
                    sel_d    = 2'd0;
                    settle_d = 8'(SETTLE_CYC - 1);
                    fb_d     = 1'b1;
                    cnt_d    = cntSat ? cnt_q : cnt_q + CNT_W'(1);
                    state_d  = SETTLE;
                end else if (accept) begin
                    if (reqFail) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d    = req_sel;
                        settle_d = 8'(SETTLE_CYC - 1);
                        cnt_d    = cntSat ? cnt_q : cnt_q + CNT_W'(1);
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // clk_fail is deliberately ignored until the mux hand-off completes.
                if (settle_q == 8'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= 8'd0;
            sel_q    <= 2'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fb_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fb_q     <= fb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sel_clk    = sel_q;
    assign busy       = (state_q == SETTLE);
    assign done       = done_q;
    assign err        = err_q;
    assign fallback   = fb_q;
    assign switch_cnt = cnt_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl: a time-based reference model predicts each
// response pulse; a negedge monitor pops and compares whenever a pulse appears.
module tb_clk_sel_ctrl;

    localparam int SETTLE = 16;
    localparam int CNTW   = 2;
    localparam int MAXC   = (1 << CNTW) - 1;
    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_FB   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            reqValid = 1'b0;
    logic [1:0]      reqSel = 2'd0;
    logic            reqReady;
    logic [2:0]      clkFail = 3'b000;
    logic [1:0]      selClk;
    logic            busy;
    logic            done;
    logic            err;
    logic            fallback;
    logic [CNTW-1:0] switchCnt;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] sel;
        int         cnt;
    } exp_t;

    exp_t sbQ[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   monOn = 1'b0;

    int         modelSel = 0;
    int         modelCnt = 0;
    int         readyCycle = 0;

    clk_sel_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_sel    (reqSel),
        .req_ready  (reqReady),
        .clk_fail   (clkFail),
        .sel_clk    (selClk),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fallback   (fallback),
        .switch_cnt (switchCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic void pushExp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.sel  = 2'(modelSel);
        e.cnt  = modelCnt;
        sbQ.push_back(e);
    endfunction

    function automatic void bumpCount();
        if (modelCnt < MAXC) modelCnt++;
    endfunction

    // Every response pulse must be predicted, on time, with matching select and count.
    always @(negedge clk) begin
        if (monOn) begin
            int n;
            exp_t e;
            n = int'(done === 1'b1) + int'(err === 1'b1) + int'(fallback === 1'b1);
            if (n > 0) begin
                checkOutput("pulses_per_cycle", n, 1);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_pulse_kind", done ? K_DONE : (err ? K_ERR : K_FB), -1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("pulse_kind", done ? K_DONE : (err ? K_ERR : K_FB), e.kind);
                    checkOutput("pulse_cycle", cyc, e.cyc);
                    checkOutput("pulse_sel", int'(selClk), int'(e.sel));
                    checkOutput("pulse_cnt", int'(switchCnt), e.cnt);
                end
            end else if (sbQ.size() != 0 && sbQ[0].cyc <= cyc) begin
                checkOutput("missing_pulse_cycle", cyc, -1);
                void'(sbQ.pop_front());
            end
        end
    end

    // One cycle of stimulus: compare steady outputs against the model, then predict this edge.
    task automatic applyStimulus(input bit v, input logic [1:0] s, input logic [2:0] f, input bit r);
        int  cur;
        bit  idle;
        bit  fb;
        bit  rdy;
        reqValid = v;
        reqSel   = s;
        clkFail  = f;
        rst      = r;
        #1;
        cur  = cyc;
        idle = (cur >= readyCycle);
        fb   = idle && (modelSel != 0) && f[modelSel];
        rdy  = idle && !fb;
        checkOutput("req_ready", int'(reqReady), int'(rdy));
        checkOutput("busy", int'(busy), int'(!idle));
        checkOutput("sel_clk", int'(selClk), modelSel);
        checkOutput("switch_cnt", int'(switchCnt), modelCnt);
        if (r) begin
            sbQ.delete();
            modelSel   = 0;
            modelCnt   = 0;
            readyCycle = cur + 1;
        end else if (fb) begin
            modelSel = 0;
            bumpCount();
            pushExp(K_FB, cur + 1);
            pushExp(K_DONE, cur + 1 + SETTLE);
            readyCycle = cur + 1 + SETTLE;
        end else if (v && rdy) begin
            if (s == 2'd3 || f[s]) begin
                pushExp(K_ERR, cur + 1);
            end else if (int'(s) == modelSel) begin
                pushExp(K_DONE, cur + 1);
            end else begin
                modelSel = int'(s);
                bumpCount();
                pushExp(K_DONE, cur + 1 + SETTLE);
                readyCycle = cur + 1 + SETTLE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] targets [5];
        targets = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        readyCycle = cyc;
        monOn      = 1'b1;

        repeat (5) applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);

        applyStimulus(1'b1, 2'd2, 3'b000, 1'b0);
        repeat (SETTLE + 1) applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);

        applyStimulus(1'b1, 2'd3, 3'b000, 1'b0);
        applyStimulus(1'b1, 2'd2, 3'b000, 1'b0);
        applyStimulus(1'b1, 2'd1, 3'b010, 1'b0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);

        // Source 2 dies with a request for source 1 pending throughout.
        repeat (2 * SETTLE + 4) applyStimulus(1'b1, 2'd1, 3'b100, 1'b0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);

        applyStimulus(1'b1, 2'd2, 3'b000, 1'b0);
        repeat (SETTLE - 8) applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1);
        repeat (SETTLE + 2) applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);

        foreach (targets[i]) begin
            applyStimulus(1'b1, targets[i], 3'b000, 1'b0);
            repeat (SETTLE) applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [2:0] f;
            f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            applyStimulus($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), f,
                          $urandom_range(0, 199) == 0);
        end

        for (int i = 0; i < 4 * SETTLE && sbQ.size() != 0; i++)
            applyStimulus(1'b0, 2'd0, 3'b000, 1'b0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
